// File: rtl/decrypt_arbiter_if.sv
// Job, response, core-side and status signals between the decrypt arbiter and its environment.
// slave = arbiter side; master = clients, response consumer and core.
interface decrypt_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_key;
    logic [DATA_W-1:0] req0_ct;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_key;
    logic [DATA_W-1:0] req1_ct;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              core_start;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_ciphertext;
    logic [DATA_W-1:0] core_decryptedtext;
    logic              core_done;
    logic              busy;

    modport slave (
        input  req0_valid, req0_key, req0_ct,
        input  req1_valid, req1_key, req1_ct,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready,
        output core_start, core_key, core_ciphertext,
        input  core_decryptedtext, core_done,
        output busy
    );

    modport master (
        output req0_valid, req0_key, req0_ct,
        output req1_valid, req1_key, req1_ct,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready,
        input  core_start, core_key, core_ciphertext,
        output core_decryptedtext, core_done,
        input  busy
    );
endinterface

// File: rtl/decrypt_arbiter.sv
// Round-robin two-requester front end for the shared decryption core; optional run timeout via DECRYPT_TIMEOUT_EN.
// Latency: accept -> core_start 1 cycle, core_done -> rsp_valid 1 cycle.
// Backpressure: one job in flight; requesters stall (ready low) outside IDLE, response held until rsp_ready.
module decrypt_arbiter #(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    decrypt_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              job_id;
    logic [DATA_W-1:0] job_key;
    logic [DATA_W-1:0] job_ct;
    logic [DATA_W-1:0] rsp_data_q;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              done_cap;
    logic              tmo_cap;
    logic              timeout_hit;

`ifdef DECRYPT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] run_cnt;
    logic             rsp_err_q;

    // run_cnt counts completed RUN cycles, so TIMEOUT_CYCLES-1 marks the last allowed one
    assign timeout_hit = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept)
                run_cnt <= '0;
            else if (state == RUN)
                run_cnt <= run_cnt + 1'b1;
            if (done_cap)
                rsp_err_q <= 1'b0;
            else if (tmo_cap)
                rsp_err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        accept     = 1'b0;
        done_cap   = 1'b0;
        tmo_cap    = 1'b0;
        case (state)
            IDLE: begin
                // prefer the requester that was not served last
                if (last_grant) begin
                    gnt0 = bus.req0_valid;
                    gnt1 = bus.req1_valid & ~bus.req0_valid;
                end else begin
                    gnt1 = bus.req1_valid;
                    gnt0 = bus.req0_valid & ~bus.req1_valid;
                end
                accept = gnt0 | gnt1;
                if (accept)
                    state_next = RUN;
            end
            RUN: begin
                if (bus.core_done) begin
                    done_cap   = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    tmo_cap    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_next = GAP;
            end
            GAP: begin
                // a lingering done would be mistaken for the next job's completion
                if (!bus.core_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            job_id     <= 1'b0;
            job_key    <= '0;
            job_ct     <= '0;
            rsp_data_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= gnt1;
                job_id     <= gnt1;
                job_key    <= gnt1 ? bus.req1_key : bus.req0_key;
                job_ct     <= gnt1 ? bus.req1_ct  : bus.req0_ct;
            end
            if (done_cap)
                rsp_data_q <= bus.core_decryptedtext;
            else if (tmo_cap)
                rsp_data_q <= '0;
        end
    end

    assign bus.req0_ready      = gnt0;
    assign bus.req1_ready      = gnt1;
    assign bus.core_start      = (state == RUN);
    assign bus.core_key        = job_key;
    assign bus.core_ciphertext = job_ct;
    assign bus.rsp_valid       = (state == RESP);
    assign bus.rsp_id          = job_id;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.busy            = (state != IDLE);

endmodule

// File: doc/decrypt_arbiter.md
Name: decrypt_arbiter

Overview:
Two-requester front end for the shared 64-bit decryption core. Accepts {key, ciphertext} jobs over valid/ready handshakes and arbitrates them round-robin. Drives the core's start/key/ciphertext inputs and holds them until the core reports done. Returns the decrypted text, requester ID and an error flag over a single valid/ready response channel. It sits between bus-side clients and the `decryption` instance.

Parameters:
DATA_W, 64, key/ciphertext/plaintext width; must match the core.
TIMEOUT_CYCLES, 1024, RUN-state cycle limit; used only with DECRYPT_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 job valid.
req0_ready  output  1  requester 0 job accepted this cycle when valid&ready.
req0_key  input  DATA_W  requester 0 key.
req0_ct  input  DATA_W  requester 0 ciphertext.
req1_valid  input  1  requester 1 job valid.
req1_ready  output  1  requester 1 accept.
req1_key  input  DATA_W  requester 1 key.
req1_ct  input  DATA_W  requester 1 ciphertext.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_id  output  1  requester that owns the response.
rsp_data  output  DATA_W  decrypted text.
rsp_err  output  1  job timed out; rsp_data is 0.
core_start  output  1  to core start.
core_key  output  DATA_W  to core key.
core_ciphertext  output  DATA_W  to core ciphertext.
core_decryptedtext  input  DATA_W  from core decryptedtext.
core_done  input  1  from core DECRYPT_DONE.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Job registers = 0. last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, RUN, RESP, GAP.
- IDLE arbitration:
  - A ready signal is asserted combinationally only in IDLE, and only to the granted requester.
  - Grant goes to the requester not equal to last_grant if it is valid; otherwise to the other requester if it is valid.
  - Only a single requester valid: it is granted.
- IDLE accept: on valid&ready in cycle N, latch key/ct/id and update last_grant. At N+1 state = RUN with core_start=1.
- RUN:
  - core_start held at 1 and core_key/core_ciphertext held stable.
  - On core_done=1: capture core_decryptedtext into rsp_data, set rsp_err=0 and rsp_valid=1, go to RESP.
- RESP:
  - core_start=0.
  - rsp_valid/rsp_id/rsp_data/rsp_err stay stable until rsp_ready. Requesters are not served; both ready signals are 0.
  - On rsp_valid&rsp_ready: rsp_valid drops the next cycle and the FSM goes to GAP.
- GAP: core_start=0. Stays until core_done=0, then IDLE. This guarantees the core sees a start low phase between jobs.
- core_done high in IDLE or GAP is ignored.
- Minimum turnaround: accept → core_start is 1 cycle; core_done → rsp_valid is 1 cycle.
- rst asserted in any state returns everything to reset values on the next edge. An in-flight job is dropped with no response. The core shares rst.
- Requesters may change data while not ready; only the data present at the handshake cycle is used.

Optional Feature:
DECRYPT_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no core_done: go to RESP with rsp_err=1 and rsp_data=0, core_start=0, then the normal GAP exit.
  - core_done and timeout in the same cycle: done wins and rsp_err=0.
- Undefined: no counter; RUN waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single job: req0 key=64'h0f1571c9ac4198de, ct=64'hda02ce3a89ecac3b, with the real core → core_start high 1 cycle after accept. rsp_valid with rsp_id=0, rsp_data=64'h02468aceeca86420, rsp_err=0.
- Contention: req0 and req1 both valid from reset with distinct jobs → req0 served first, then req1. Repeat both valid → req0 served again (alternation). Check ids and data per job.
- Backpressure: rsp_ready held 0 for 20 cycles → rsp_* stable. req0_ready and req1_ready stay 0. No second core_start until after the handshake and GAP.
- Sticky done: core model holds core_done high 3 cycles after the response → FSM stays in GAP. The next job's core_start appears only after core_done falls.
- Reset mid-RUN: assert rst 5 cycles into a job → next cycle core_start=0, busy=0, rsp_valid=0. First job after reset is granted to req0 when both are valid.
- Timeout (DECRYPT_TIMEOUT_EN, TIMEOUT_CYCLES=16): core model never asserts done → rsp_valid after 16 RUN cycles with rsp_err=1 and rsp_data=0. A subsequent job completes normally.
